// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0020;
    localparam int          INSN_BYTES = 4;

    // One prefetch-buffer entry: the fetched word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and a combinational head read.
// Used both as the prefetch buffer and as the in-flight request PC queue.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Qualify push/pop against the current occupancy and expose status.
    always_comb begin
        empty     = (count_r == {CNT_W{1'b0}});
        full      = (count_r == CNT_W'(DEPTH));
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        count     = count_r;
        head_data = mem_r[rd_ptr_r];
    end

    // Pointer and occupancy update; flush empties the queue and wins over push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; cleared on reset so the head never reads unknown data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/if_fetch_unit_chk.sv
// Protocol and consistency assertions for the fetch stage.
module if_fetch_unit_chk #(
    parameter int OUT_W = 2
) (
    input logic             clk,
    input logic             reset_n,
    input logic             imem_rsp_valid,
    input logic [OUT_W-1:0] outstanding,
    input logic [OUT_W-1:0] drop_cnt,
    input logic [OUT_W-1:0] tag_count,
    input logic             tag_push,
    input logic             tag_full,
    input logic             tag_empty,
    input logic             buf_push,
    input logic             buf_full
);

    a_no_buf_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(buf_push && buf_full));

    a_no_tag_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(tag_push && tag_full));

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rsp_valid && (outstanding == {OUT_W{1'b0}})));

    a_push_has_tag: assert property (@(posedge clk) disable iff (!reset_n)
        !(buf_push && tag_empty));

    // Every live (non-dropped) request holds exactly one PC tag.
    a_tag_matches_live: assert property (@(posedge clk) disable iff (!reset_n)
        tag_count == (outstanding - drop_cnt));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests,
// in-order response tagging, prefetch buffering and redirect flushing.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN            = if_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = {XLEN{1'b0}},
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [31:0]     NOP_INSN        = if_pkg::NOP_INSN
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [31:0]     instruction,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc
);

    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = XLEN + 32;

    logic [XLEN-1:0]    fetch_pc_r;
    logic [OUT_W-1:0]   outstanding_r;
    logic [OUT_W-1:0]   drop_cnt_r;
    logic               run_r;

    logic               req_hs_s;
    logic [OUT_W-1:0]   outstanding_nxt_s;
    logic [31:0]        credit_s;
    logic               tag_pop_s;
    logic               buf_push_s;
    logic               buf_pop_s;
    logic [ENTRY_W-1:0] buf_head_s;
    logic [CNT_W-1:0]   buf_count_s;
    logic               buf_empty_s;
    logic               buf_full_s;
    logic [XLEN-1:0]    tag_head_s;
    logic [OUT_W-1:0]   tag_count_s;
    logic               tag_empty_s;
    logic               tag_full_s;

    // Request credit, response routing and outstanding bookkeeping.
    always_comb begin
        credit_s       = 32'(outstanding_r) + 32'(buf_count_s);
        imem_req_valid = run_r && !redirect_valid
                         && (outstanding_r < OUT_W'(MAX_OUTSTANDING))
                         && (credit_s < 32'(FIFO_DEPTH));
        imem_req_addr  = fetch_pc_r;
        req_hs_s       = imem_req_valid && imem_req_ready;
        // A live response consumes its tag; during a redirect it is lost in the flush.
        tag_pop_s      = imem_rsp_valid && (drop_cnt_r == {OUT_W{1'b0}});
        buf_push_s     = tag_pop_s && !redirect_valid;
        buf_pop_s      = !buf_empty_s && id_ready && !redirect_valid;
        case ({req_hs_s, imem_rsp_valid})
            2'b10:   outstanding_nxt_s = outstanding_r + OUT_W'(1);
            2'b01:   outstanding_nxt_s = outstanding_r - OUT_W'(1);
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Fetch PC, in-flight count, stale-response counter and post-reset enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= {OUT_W{1'b0}};
            drop_cnt_r    <= {OUT_W{1'b0}};
            run_r         <= 1'b0;
        end else begin
            run_r         <= 1'b1;
            outstanding_r <= outstanding_nxt_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc & ~(XLEN'(INSN_BYTES - 1));
                drop_cnt_r <= outstanding_nxt_s;
            end else begin
                if (req_hs_s) begin
                    fetch_pc_r <= fetch_pc_r + XLEN'(INSN_BYTES);
                end else begin
                    fetch_pc_r <= fetch_pc_r;
                end
                if (imem_rsp_valid && (drop_cnt_r != {OUT_W{1'b0}})) begin
                    drop_cnt_r <= drop_cnt_r - OUT_W'(1);
                end else begin
                    drop_cnt_r <= drop_cnt_r;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (XLEN)
    ) u_tag_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (req_hs_s),
        .push_data (fetch_pc_r),
        .pop       (tag_pop_s),
        .head_data (tag_head_s),
        .count     (tag_count_s),
        .empty     (tag_empty_s),
        .full      (tag_full_s)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_prefetch_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (buf_push_s),
        .push_data ({tag_head_s, imem_rsp_data}),
        .pop       (buf_pop_s),
        .head_data (buf_head_s),
        .count     (buf_count_s),
        .empty     (buf_empty_s),
        .full      (buf_full_s)
    );

    // Present the buffer head to ID; an empty buffer shows a NOP at address 0.
    always_comb begin
        id_valid = !buf_empty_s;
        if (buf_empty_s) begin
            instruction = NOP_INSN;
            pc          = {XLEN{1'b0}};
            next_pc     = {XLEN{1'b0}};
        end else begin
            instruction = buf_head_s[31:0];
            pc          = buf_head_s[ENTRY_W-1:32];
            next_pc     = buf_head_s[ENTRY_W-1:32] + XLEN'(INSN_BYTES);
        end
    end

    if_fetch_unit_chk #(
        .OUT_W (OUT_W)
    ) u_chk (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_rsp_valid (imem_rsp_valid),
        .outstanding    (outstanding_r),
        .drop_cnt       (drop_cnt_r),
        .tag_count      (tag_count_s),
        .tag_push       (req_hs_s),
        .tag_full       (tag_full_s),
        .tag_empty      (tag_empty_s),
        .buf_push       (buf_push_s),
        .buf_full       (buf_full_s)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a variable-latency in-order memory
// model plus a stream-level reference of what ID and imem should observe.
module tb_if_fetch_unit;

    localparam int          FIFO_DEPTH = 4;
    localparam int          MAX_OUT    = 2;
    localparam logic [31:0] NOP        = 32'h0000_0020;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] next_pc;

    if_fetch_unit #(
        .XLEN            (32),
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .NOP_INSN        (NOP)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .instruction    (instruction),
        .pc             (pc),
        .next_pc        (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    int          tests;
    int          fails;
    int          cyc;
    int          latency;
    bit          rnd_ready;
    mreq_t       mq[$];
    int          last_due;
    // Reference state: next expected fetch address, next expected ID pc,
    // requests in flight, fresh words buffered, and redirect epoch.
    logic [31:0] exp_req;
    logic [31:0] exp_id;
    int          m_out;
    int          m_buf;
    int          epoch;
    bit          rsp_fresh;
    bit          last_rsp;
    bit          last_idv;
    logic [31:0] q_req_addr[$];
    logic [31:0] q_id_pc[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // One clock cycle: drive memory, check every observable output, update the model.
    task automatic tick();
        bit          exp_rv;
        bit          req_hs;
        bit          id_hs;
        int          due;
        logic [31:0] tgt;
        @(negedge clk);
        imem_req_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mq[0].addr);
            rsp_fresh      = (mq[0].epoch == epoch);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            rsp_fresh      = 1'b0;
        end
        #1;
        exp_rv = !redirect_valid && (m_out < MAX_OUT) && (m_out + m_buf < FIFO_DEPTH);
        tests++;
        if (imem_req_valid !== exp_rv) begin
            fails++;
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_rv);
        end
        if (imem_req_valid === 1'b1) begin
            tests++;
            if (imem_req_addr !== exp_req) begin
                fails++;
                $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, exp_req);
            end
        end
        tests++;
        if (id_valid !== (m_buf > 0)) begin
            fails++;
            $display("FAIL id_valid cyc=%0d: got %b expected %b", cyc, id_valid, (m_buf > 0));
        end
        tests++;
        if (m_buf > 0) begin
            if (pc !== exp_id || instruction !== memf(exp_id) || next_pc !== exp_id + 32'd4) begin
                fails++;
                $display("FAIL id_head cyc=%0d: got pc=%h insn=%h npc=%h expected pc=%h insn=%h npc=%h",
                         cyc, pc, instruction, next_pc, exp_id, memf(exp_id), exp_id + 32'd4);
            end
        end else begin
            if (pc !== 32'd0 || instruction !== NOP || next_pc !== 32'd0) begin
                fails++;
                $display("FAIL id_empty cyc=%0d: got pc=%h insn=%h npc=%h expected 0/%h/0",
                         cyc, pc, instruction, next_pc, NOP);
            end
        end
        last_rsp = imem_rsp_valid;
        last_idv = id_valid;
        req_hs   = imem_req_valid && imem_req_ready;
        id_hs    = id_valid && id_ready && !redirect_valid;
        if (req_hs) begin
            due = cyc + latency;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
            q_req_addr.push_back(imem_req_addr);
            exp_req = exp_req + 32'd4;
        end
        m_out = m_out + int'(req_hs) - int'(imem_rsp_valid);
        if (redirect_valid) begin
            tgt     = redirect_pc;
            tgt     = {tgt[31:2], 2'b00};
            epoch++;
            m_buf   = 0;
            exp_req = tgt;
            exp_id  = tgt;
        end else begin
            if (imem_rsp_valid && rsp_fresh) m_buf++;
            if (id_hs) begin
                q_id_pc.push_back(pc);
                m_buf--;
                exp_id = exp_id + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        rnd_ready      = 1'b0;
        latency        = 1;
        mq.delete();
        q_req_addr.delete();
        q_id_pc.delete();
        m_out    = 0;
        m_buf    = 0;
        exp_req  = 32'd0;
        exp_id   = 32'd0;
        epoch++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        last_due = cyc;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests++;
        if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        tests++;
        if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid: got %b expected 0", id_valid); end
        tests++;
        if (instruction !== NOP) begin fails++; $display("FAIL rst_insn: got %h expected %h", instruction, NOP); end
        tests++;
        if (pc !== 32'd0 || next_pc !== 32'd0) begin fails++; $display("FAIL rst_pc: got %h/%h expected 0/0", pc, next_pc); end
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        id_ready = 1'b1;
        repeat (20) tick();
        tests++;
        if (q_req_addr.size() < 3 || q_req_addr[0] !== 32'd0 || q_req_addr[1] !== 32'd4 || q_req_addr[2] !== 32'd8) begin
            fails++;
            $display("FAIL seq_req_addrs: got %0d reqs first=%h expected 0,4,8",
                     q_req_addr.size(), (q_req_addr.size() > 0) ? q_req_addr[0] : 32'hx);
        end
        tests++;
        if (q_id_pc.size() < 3 || q_id_pc[0] !== 32'd0 || q_id_pc[1] !== 32'd4 || q_id_pc[2] !== 32'd8) begin
            fails++;
            $display("FAIL seq_id_pcs: got %0d pops expected pcs 0,4,8", q_id_pc.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        id_ready = 1'b0;
        repeat (10) tick();
        tests++;
        if (q_req_addr.size() != FIFO_DEPTH) begin
            fails++;
            $display("FAIL bp_req_count: got %0d expected %0d", q_req_addr.size(), FIFO_DEPTH);
        end
        id_ready = 1'b1;
        repeat (8) tick();
        tests++;
        if (q_id_pc.size() < 4 || q_id_pc[0] !== 32'd0 || q_id_pc[1] !== 32'd4
            || q_id_pc[2] !== 32'd8 || q_id_pc[3] !== 32'd12) begin
            fails++;
            $display("FAIL bp_drain: got %0d pops expected pcs 0,4,8,12", q_id_pc.size());
        end
    endtask

    task automatic test_redirect_latency();
        int n;
        do_reset();
        latency  = 3;
        id_ready = 1'b1;
        n = 0;
        while (m_out < 2 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (m_out != 2) begin fails++; $display("FAIL lat_outstanding: got %0d expected 2", m_out); end
        redirect_to(32'h0000_0100);
        q_id_pc.delete();
        repeat (30) tick();
        tests++;
        if (q_id_pc.size() == 0 || q_id_pc[0] !== 32'h0000_0100) begin
            fails++;
            $display("FAIL lat_first_pc: got %h expected 00000100",
                     (q_id_pc.size() > 0) ? q_id_pc[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_collide();
        logic [31:0] tgt;
        do_reset();
        id_ready = 1'b1;
        repeat (6) tick();
        tgt = {$urandom_range(1, 16'hFFFF), 2'b00};
        redirect_to(tgt);
        tests++;
        if (!(last_rsp && last_idv === 1'b1)) begin
            fails++;
            $display("FAIL col_setup: got rsp=%b id_valid=%b expected 1/1", last_rsp, last_idv);
        end
        q_id_pc.delete();
        tick();
        tests++;
        if (last_idv !== 1'b0) begin fails++; $display("FAIL col_flushed: got id_valid %b expected 0", last_idv); end
        repeat (10) tick();
        tests++;
        if (q_id_pc.size() == 0 || q_id_pc[0] !== tgt) begin
            fails++;
            $display("FAIL col_first_pc: got %h expected %h", (q_id_pc.size() > 0) ? q_id_pc[0] : 32'hx, tgt);
        end
    endtask

    task automatic test_align_wrap();
        do_reset();
        id_ready = 1'b1;
        repeat (3) tick();
        redirect_to(32'h0000_0103);
        q_req_addr.delete();
        repeat (4) tick();
        tests++;
        if (q_req_addr.size() == 0 || q_req_addr[0] !== 32'h0000_0100) begin
            fails++;
            $display("FAIL align_addr: got %h expected 00000100", (q_req_addr.size() > 0) ? q_req_addr[0] : 32'hx);
        end
        redirect_to(32'hFFFF_FFFC);
        q_req_addr.delete();
        q_id_pc.delete();
        repeat (8) tick();
        tests++;
        if (q_req_addr.size() < 2 || q_req_addr[0] !== 32'hFFFF_FFFC || q_req_addr[1] !== 32'd0) begin
            fails++;
            $display("FAIL wrap_addr: got %0d reqs expected FFFFFFFC then 0", q_req_addr.size());
        end
        tests++;
        if (q_id_pc.size() < 2 || q_id_pc[0] !== 32'hFFFF_FFFC || q_id_pc[1] !== 32'd0) begin
            fails++;
            $display("FAIL wrap_id: got %0d pops expected pcs FFFFFFFC then 0", q_id_pc.size());
        end
    endtask

    task automatic test_reset_midburst();
        int n;
        do_reset();
        latency  = 3;
        id_ready = 1'b1;
        n = 0;
        while (m_out < 2 && n < 20) begin
            tick();
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || instruction !== NOP || pc !== 32'd0 || next_pc !== 32'd0) begin
            fails++;
            $display("FAIL midrst_outputs: got rv=%b iv=%b insn=%h pc=%h npc=%h expected 0/0/%h/0/0",
                     imem_req_valid, id_valid, instruction, pc, next_pc, NOP);
        end
        do_reset();
        id_ready = 1'b1;
        repeat (10) tick();
        tests++;
        if (q_req_addr.size() == 0 || q_req_addr[0] !== 32'd0 || q_id_pc.size() == 0 || q_id_pc[0] !== 32'd0) begin
            fails++;
            $display("FAIL midrst_refetch: got %0d reqs %0d pops expected restart at 0", q_req_addr.size(), q_id_pc.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        rnd_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) latency = $urandom_range(1, 4);
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_to($urandom);
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        epoch = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_latency();
        test_redirect_collide();
        test_align_wrap();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
